// File: rtl/vedic_mul_pkg.sv
// Shared types and constants for the sequential vedic multiplier.
// The FSM state type and the partial-product shift amounts live here so the
// controller and any future siblings agree on them.
package vedic_mul_pkg;

    localparam int unsigned VM_W_DEFAULT = 8;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PP0  = 3'd1,
        PP1  = 3'd2,
        PP2  = 3'd3,
        PP3  = 3'd4,
        DONE = 3'd5
    } vm_state_e;

    // Half-operand width: size of each sub-multiplier input.
    function automatic int unsigned vm_half_w(input int unsigned w);
        return w / 2;
    endfunction

    // Shift applied to the cross terms aH*bL and aL*bH.
    function automatic int unsigned vm_sh_mid(input int unsigned w);
        return w / 2;
    endfunction

    // Shift applied to the high term aH*bH.
    function automatic int unsigned vm_sh_hi(input int unsigned w);
        return w;
    endfunction

endpackage

// File: rtl/vedic_mul_half.sv
// Combinational HW x HW unsigned multiplier, Urdhva-Tiryagbhyam style:
// every result column k collects the vertical/crosswise bit products
// x[i]&y[j] with i+j == k, and the column sums are added with their weight.
module vedic_mul_half #(
    parameter int unsigned HW = 4
) (
    input  logic [HW-1:0]   x_i,
    input  logic [HW-1:0]   y_i,
    output logic [2*HW-1:0] p_o
);

    localparam int unsigned PW = 2 * HW;

    logic [PW-1:0] col_sum;
    logic [PW-1:0] total;

    // Column-wise crosswise accumulation of the bit products.
    always_comb begin
        col_sum = '0;
        total   = '0;
        for (int k = 0; k < 2 * HW - 1; k++) begin
            col_sum = '0;
            for (int i = 0; i < HW; i++) begin
                for (int j = 0; j < HW; j++) begin
                    if (i + j == k) begin
                        col_sum = col_sum + PW'(x_i[i] & y_i[j]);
                    end
                end
            end
            total = total + (col_sum << k);
        end
        p_o = total;
    end

endmodule

// File: rtl/vedic_mul_seq_ctrl.sv
// Sequential W x W unsigned multiplier that time-shares one (W/2)x(W/2)
// vedic sub-multiplier over four partial products (aL*bL, aH*bL, aL*bH,
// aH*bH), accumulating into a 2W-bit register. A result appears every
// 5 cycles; start is honoured in IDLE and in the DONE cycle only.
// Optional macro VEDIC_MUL_ZERO_SKIP_EN: a zero operand finishes in one
// cycle with product 0 and busy never raised.
module vedic_mul_seq_ctrl
    import vedic_mul_pkg::*;
#(
    parameter int unsigned W = VM_W_DEFAULT   // even, >= 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic           busy,
    output logic           done,
    output logic [2*W-1:0] product
);

    localparam int unsigned HW     = vm_half_w(W);
    localparam int unsigned PW     = 2 * W;
    localparam int unsigned SH_MID = vm_sh_mid(W);
    localparam int unsigned SH_HI  = vm_sh_hi(W);

    vm_state_e      state_q, state_d;
    logic [W-1:0]   a_q, a_d;
    logic [W-1:0]   b_q, b_d;
    logic [PW-1:0]  acc_q, acc_d;
    logic [PW-1:0]  product_q, product_d;

    logic [HW-1:0]  mul_x, mul_y;
    logic [W-1:0]   pp;
    logic [PW-1:0]  pp_shifted;
    logic [PW-1:0]  acc_sum;

    vedic_mul_half #(.HW(HW)) u_half (
        .x_i (mul_x),
        .y_i (mul_y),
        .p_o (pp)
    );

    // Route operand halves to the shared sub-multiplier and weight its result.
    always_comb begin
        mul_x      = a_q[HW-1:0];
        mul_y      = b_q[HW-1:0];
        pp_shifted = '0;
        case (state_q)
            PP0: begin
                mul_x      = a_q[HW-1:0];
                mul_y      = b_q[HW-1:0];
                pp_shifted = PW'(pp);
            end
            PP1: begin
                mul_x      = a_q[W-1:HW];
                mul_y      = b_q[HW-1:0];
                pp_shifted = PW'(pp) << SH_MID;
            end
            PP2: begin
                mul_x      = a_q[HW-1:0];
                mul_y      = b_q[W-1:HW];
                pp_shifted = PW'(pp) << SH_MID;
            end
            PP3: begin
                mul_x      = a_q[W-1:HW];
                mul_y      = b_q[W-1:HW];
                pp_shifted = PW'(pp) << SH_HI;
            end
            default: begin
                pp_shifted = '0;
            end
        endcase
        acc_sum = acc_q + pp_shifted;
    end

    // Next-state, datapath updates and status outputs.
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        acc_d     = acc_q;
        product_d = product_q;
        busy      = 1'b0;
        done      = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                done = (state_q == DONE);
                if (start) begin
                    a_d   = a;
                    b_d   = b;
                    acc_d = '0;
`ifdef VEDIC_MUL_ZERO_SKIP_EN
                    if ((a == '0) || (b == '0)) begin
                        state_d   = DONE;
                        product_d = '0;
                    end else begin
                        state_d = PP0;
                    end
`else
                    state_d = PP0;
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            PP0: begin
                busy    = 1'b1;
                acc_d   = acc_sum;
                state_d = PP1;
            end
            PP1: begin
                busy    = 1'b1;
                acc_d   = acc_sum;
                state_d = PP2;
            end
            PP2: begin
                busy    = 1'b1;
                acc_d   = acc_sum;
                state_d = PP3;
            end
            PP3: begin
                busy      = 1'b1;
                acc_d     = acc_sum;
                product_d = acc_sum;
                state_d   = DONE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset clears everything at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            acc_q     <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            acc_q     <= acc_d;
            product_q <= product_d;
        end
    end

    assign product = product_q;

endmodule

// File: tb/tb_vedic_mul_seq_ctrl.sv
// Directed + randomized bench for vedic_mul_seq_ctrl (W=8).
// Reference: product = a*b, completion 5 cycles after acceptance
// (1 cycle for a zero operand when VEDIC_MUL_ZERO_SKIP_EN is defined).
module tb_vedic_mul_seq_ctrl;

    localparam int W = 8;

    logic           clk;
    logic           rst_n;
    logic           start;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           busy;
    logic           done;
    logic [2*W-1:0] product;

    int n_cmp;
    int n_mis;
    logic [2*W-1:0] exp_prod;

    vedic_mul_seq_ctrl #(.W(W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int op_latency(input logic [W-1:0] av, input logic [W-1:0] bv);
`ifdef VEDIC_MUL_ZERO_SKIP_EN
        if (av == 0 || bv == 0) return 1;
`endif
        return 5;
    endfunction

    // Launch one multiply (state must be IDLE or DONE) and follow it to its
    // completion cycle; operands and start are scrambled while in flight.
    task automatic do_op(input logic [W-1:0] av, input logic [W-1:0] bv, input string tag);
        int lat;
        logic [2*W-1:0] want;
        lat  = op_latency(av, bv);
        want = 16'(av) * 16'(bv);
        a = av;
        b = bv;
        start = 1'b1;
        for (int c = 1; c <= lat; c++) begin
            step();
            if (c < lat) begin
                start = 1'($urandom_range(0, 1));
                a = 8'($urandom);
                b = 8'($urandom);
            end else begin
                start = 1'b0;
            end
            chk({tag, "_busy"}, 32'(busy), 32'(c < lat));
            chk({tag, "_done"}, 32'(done), 32'(c == lat));
            if (c < lat) chk({tag, "_hold"}, 32'(product), 32'(exp_prod));
        end
        exp_prod = want;
        chk({tag, "_prod"}, 32'(product), 32'(want));
    endtask

    initial begin
        n_cmp = 0;
        n_mis = 0;
        exp_prod = '0;
        rst_n = 1'b0;
        start = 1'b0;
        a = '0;
        b = '0;
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_prod", 32'(product), 32'd0);
        step();
        step();
        rst_n = 1'b1;

        // FF x FF from IDLE, then one idle cycle
        do_op(8'hFF, 8'hFF, "ffff");
        chk("ffff_val", 32'(product), 32'h0000FE01);
        step();
        chk("ffff_after_done", 32'(done), 32'd0);
        chk("ffff_after_busy", 32'(busy), 32'd0);
        chk("ffff_after_prod", 32'(product), 32'h0000FE01);

        // Continuous start with fixed operands: done every 5th cycle
        a = 8'h12;
        b = 8'h34;
        start = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            step();
            chk("cont_done", 32'(done), 32'(c % 5 == 0));
            chk("cont_busy", 32'(busy), 32'(c % 5 != 0));
            if (c % 5 == 0) chk("cont_prod", 32'(product), 32'h000003A8);
        end
        start = 1'b0;
        exp_prod = 16'h03A8;
        step();
        chk("cont_stop_done", 32'(done), 32'd0);

        // start during cycle 2 with new operands is ignored
        a = 8'h9C;
        b = 8'h27;
        start = 1'b1;
        step();
        start = 1'b0;
        a = 8'h00;
        b = 8'h00;
        step();
        start = 1'b1;
        a = 8'h11;
        b = 8'h22;
        step();
        start = 1'b0;
        chk("ign_busy3", 32'(busy), 32'd1);
        step();
        chk("ign_busy4", 32'(busy), 32'd1);
        step();
        chk("ign_done5", 32'(done), 32'd1);
        chk("ign_prod5", 32'(product), 32'(16'(8'h9C) * 16'(8'h27)));
        exp_prod = 16'(8'h9C) * 16'(8'h27);
        step();
        chk("ign_done6", 32'(done), 32'd0);
        chk("ign_busy6", 32'(busy), 32'd0);
        step();
        chk("ign_done7", 32'(done), 32'd0);

        // Back-to-back accepted in the DONE cycle
        do_op(8'h3C, 8'hA5, "b2b_a");
        do_op(8'h81, 8'h7E, "b2b_b");
        step();

        // Reset in cycle 3 of AB x CD
        a = 8'hAB;
        b = 8'hCD;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        #3;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        chk("mid_rst_prod", 32'(product), 32'd0);
        exp_prod = '0;
        step();
        chk("mid_rst_done2", 32'(done), 32'd0);
        step();
        rst_n = 1'b1;
        do_op(8'hAB, 8'hCD, "abcd");
        chk("abcd_val", 32'(product), 32'h000088EF);
        step();

        // Zero operands
        do_op(8'h00, 8'h5A, "zero_a");
        step();
        chk("zero_a_idle_done", 32'(done), 32'd0);
        do_op(8'h5A, 8'h00, "zero_b");
        do_op(8'hC3, 8'h00, "zero_b2b");
        do_op(8'hC3, 8'h77, "after_zero");
        step();

        // Randomized sweep with boundary values mixed in
        for (int n = 0; n < 300; n++) begin
            logic [W-1:0] av;
            logic [W-1:0] bv;
            av = 8'($urandom);
            bv = 8'($urandom);
            if (n % 17 == 0) av = 8'hFF;
            if (n % 23 == 0) bv = 8'hFF;
            if (n % 29 == 0) av = 8'h00;
            if (n % 31 == 0) bv = 8'h01;
            do_op(av, bv, "rand");
            if ($urandom_range(0, 3) == 0) begin
                step();
                chk("rand_idle_done", 32'(done), 32'd0);
                chk("rand_idle_busy", 32'(busy), 32'd0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/vedic_mul_seq_ctrl.md
VEDIC_MUL_SEQ_CTRL -- requirements
Module: vedic_mul_seq_ctrl

Interface
REQ-001 Parameter W, default 8, meaning operand width; SHALL be even and >= 4; sub-multiplier width is W/2.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset; asynchronous assert, active-low.
REQ-004 start  input  1  request to begin a multiply; sampled on rising clk.
REQ-005 a  input  W  multiplicand, unsigned; sampled only when start is accepted.
REQ-006 b  input  W  multiplier, unsigned; sampled only when start is accepted.
REQ-007 busy  output  1  high while a multiply is in progress.
REQ-008 done  output  1  single-cycle pulse marking product valid.
REQ-009 product  output  2W  registered result; holds last result until next completion.

Function
REQ-010 Block SHALL time-share one combinational (W/2)x(W/2) sub-multiplier over four partial products.
REQ-011 FSM states SHALL be IDLE, PP0, PP1, PP2, PP3, DONE.
REQ-012 Transitions: IDLE->PP0 on start; PP0->PP1->PP2->PP3->DONE unconditionally; DONE->PP0 on start, else DONE->IDLE.
REQ-013 Start acceptance (cycle 0, state IDLE or DONE) SHALL latch a, b and clear the 2W-bit accumulator.
REQ-014 Partial products: PP0=aL*bL shift 0; PP1=aH*bL shift W/2; PP2=aL*bH shift W/2; PP3=aH*bH shift W; each added into the accumulator at the end of its state.
REQ-015 Accumulator SHALL be 2W bits; no intermediate sum exceeds 2W bits; no overflow handling needed.
REQ-016 busy SHALL be high exactly in states PP0..PP3 (cycles 1-4 after acceptance).
REQ-017 On PP3->DONE, product SHALL load the final accumulator value; done SHALL be high for exactly the DONE cycle (cycle 5).
REQ-018 start while busy SHALL be ignored; operands, accumulator and sequence unaffected.
REQ-019 start in DONE cycle SHALL be accepted (back-to-back); done still pulses for the finishing operation, product unchanged until the new operation completes.
REQ-020 Changes on a/b after acceptance SHALL NOT affect the in-flight result.
REQ-021 Throughput SHALL be one result per 5 cycles under continuous start.

Reset
REQ-022 rst_n low SHALL immediately force state IDLE, busy=0, done=0, product=0, accumulator=0, latched operands=0.
REQ-023 Reset mid-operation SHALL abort the multiply with no done pulse; first start after release SHALL behave as from power-up.
REQ-024 start high in the first clock edge after rst_n deassertion SHALL be accepted normally.

Configuration
REQ-025 Macro VEDIC_MUL_ZERO_SKIP_EN, when defined, SHALL make a start with a==0 or b==0 go directly to DONE (cycle 1), product=0, busy never asserted.
REQ-026 Without VEDIC_MUL_ZERO_SKIP_EN, zero operands SHALL take the full PP0..PP3 sequence and yield product=0 at cycle 5.

Structure
REQ-027 Package vedic_mul_pkg SHALL hold the FSM state enum typedef and the shift-amount constants derived from W.
REQ-028 Sub-module vedic_mul_half SHALL implement the combinational (W/2)x(W/2) vedic multiplier from the existing half-adder and adder cells; controller instantiates exactly one.

Verification
REQ-029 W=8, a=0xFF, b=0xFF, start pulse in cycle 0 -> busy cycles 1-4, done in cycle 5, product=0xFE01.
REQ-030 a=0x12, b=0x34, then start held high continuously -> product=0x03A8 with done every 5 cycles, no dropped or duplicated pulses.
REQ-031 start asserted in cycle 2 of an operation with new operands -> ignored; original product delivered in cycle 5, no second done.
REQ-032 rst_n low in cycle 3 of a=0xAB, b=0xCD -> outputs 0 immediately, no done; subsequent a=0xAB, b=0xCD -> product=0x88EF.
REQ-033 a=0x00, b=0x5A: with VEDIC_MUL_ZERO_SKIP_EN -> done cycle 1, busy low, product=0; without -> done cycle 5, product=0.
REQ-034 Random a/b sweep (all 65536 pairs for W=8) -> product equals a*b for every completion.
